// File: rtl/fp_round_unit.sv
// Purpose : final rounding stage for single-precision FP results; applies the
//           RISC-V rounding mode, resolves overflow/special values, builds fflags.
// Latency : 2 cycles accept-to-valid_o, 1 result per cycle; clk_en_i=0 freezes all state.
// Backpressure: ready_o is combinational from ready_i; result_o/fflags_o hold while valid_o & ~ready_i.
//
// Ports:
//   clk_i, rst_i (sync, active-high), clk_en_i (stage enable)
//   valid_i/ready_o        : input handshake
//   to_round_i             : unrounded {sign, exp[7:0], mant[22:0]}
//   round_bits_i           : {guard, round, sticky}
//   rounding_mode_i        : RNE=000 RTZ=001 RDN=010 RUP=011 RMM=100, others reserved
//   overflow_i, underflow_i, invalid_op_i, zero_divide_i : upstream exception flags
//   valid_o/ready_i        : output handshake
//   result_o               : rounded result
//   fflags_o               : {NV, DZ, OF, UF, NX}
module fp_round_unit #(
   parameter logic [31:0] MAX_FINITE   = 32'h7F7FFFFF,
   parameter logic [31:0] CANO_NAN_VAL = 32'h7FC00000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clk_en_i,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [31:0] to_round_i,
   input  logic [2:0]  round_bits_i,
   input  logic [2:0]  rounding_mode_i,
   input  logic        overflow_i,
   input  logic        underflow_i,
   input  logic        invalid_op_i,
   input  logic        zero_divide_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] result_o,
   output logic [4:0]  fflags_o
);

   localparam logic [2:0]  RM_RNE  = 3'b000;
   localparam logic [2:0]  RM_RTZ  = 3'b001;
   localparam logic [2:0]  RM_RDN  = 3'b010;
   localparam logic [2:0]  RM_RUP  = 3'b011;
   localparam logic [2:0]  RM_RMM  = 3'b100;
   localparam logic [30:0] INF_MAG = {8'hFF, 23'd0};

   // ---------------- stage-1 combinational: round-up decision + classify
   logic        w_sign;
   logic [7:0]  w_exp;
   logic [22:0] w_mant;
   logic        w_g, w_r, w_s;
   logic        w_inx;
   logic        w_rup;
   logic        w_rsvd;
   logic        w_special;
   logic        w_nan;
   logic        w_inf;
   logic        w_zero;

   assign w_sign        = to_round_i[31];
   assign w_exp         = to_round_i[30:23];
   assign w_mant        = to_round_i[22:0];
   assign {w_g, w_r, w_s} = round_bits_i;
   assign w_inx         = w_g | w_r | w_s;

   always_comb begin
      w_rup  = 1'b0;
      w_rsvd = 1'b0;
      case (rounding_mode_i)
         RM_RNE:  w_rup = w_g & (w_r | w_s | w_mant[0]);
         RM_RTZ:  w_rup = 1'b0;
         RM_RDN:  w_rup = w_sign & w_inx;
         RM_RUP:  w_rup = ~w_sign & w_inx;
         RM_RMM:  w_rup = w_g;
         default: w_rsvd = 1'b1;
      endcase
   end

   // An all-ones exponent arriving together with overflow_i is an overflowed
   // magnitude from upstream, not a genuine NaN/Inf operand, so it goes down
   // the overflow path instead of the special-value path.
   assign w_special = (w_exp == 8'hFF) & ~overflow_i;
   assign w_nan     = w_special & (|w_mant);
   assign w_inf     = w_special & ~(|w_mant);
   assign w_zero    = (w_exp == 8'd0) & ~(|w_mant);

   // ---------------- handshake
   logic r_s1_valid;
   logic r_valid;
   logic w_s2_adv;
   logic w_accept;

   assign w_s2_adv = ~r_valid | ready_i;
   assign ready_o  = clk_en_i & (~r_s1_valid | w_s2_adv);
   assign w_accept = valid_i & ready_o;

   // ---------------- stage-1 registers
   logic        r_s1_sign;
   logic [30:0] r_s1_mag;
   logic        r_s1_rup;
   logic        r_s1_inx;
   logic        r_s1_rsvd;
   logic [2:0]  r_s1_mode;
   logic        r_s1_nan;
   logic        r_s1_inf;
   logic        r_s1_zero;
   logic        r_s1_ovf_in;
   logic        r_s1_uf_in;
   logic        r_s1_inv_in;
   logic        r_s1_dz_in;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_s1_valid <= 1'b0;
      end else if (ready_o) begin
         // ready_o already implies clk_en_i and room downstream of stage 1
         r_s1_valid <= valid_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         r_s1_sign   <= w_sign;
         r_s1_mag    <= to_round_i[30:0];
         r_s1_rup    <= w_rup;
         r_s1_inx    <= w_inx;
         r_s1_rsvd   <= w_rsvd;
         r_s1_mode   <= rounding_mode_i;
         r_s1_nan    <= w_nan;
         r_s1_inf    <= w_inf;
         r_s1_zero   <= w_zero;
         r_s1_ovf_in <= overflow_i;
         r_s1_uf_in  <= underflow_i;
         r_s1_inv_in <= invalid_op_i;
         r_s1_dz_in  <= zero_divide_i;
      end
   end

   // ---------------- stage-2 combinational: increment + result select
   logic [30:0] w_sum;
   logic        w_ovf;
   logic [31:0] w_res;
   logic [4:0]  w_flags;

   // A mantissa carry ripples into the exponent, which is exactly the
   // renormalisation needed after rounding 1.111..1 up.
   assign w_sum = r_s1_mag + {30'd0, r_s1_rup};
   assign w_ovf = r_s1_ovf_in | (w_sum[30:23] == 8'hFF);

   always_comb begin
      w_res   = {r_s1_sign, w_sum};
      w_flags = 5'b00000;
      if (r_s1_inv_in | r_s1_rsvd) begin
         w_res   = CANO_NAN_VAL;
         w_flags = 5'b10000;
      end else if (r_s1_dz_in) begin
         w_res   = {r_s1_sign, INF_MAG};
         w_flags = 5'b01000;
      end else if (r_s1_nan) begin
         // only a signalling NaN (quiet bit clear) raises NV
         w_res   = CANO_NAN_VAL;
         w_flags = {~r_s1_mag[22], 4'b0000};
      end else if (r_s1_inf) begin
         w_res   = {r_s1_sign, r_s1_mag};
         w_flags = 5'b00000;
      end else if (w_ovf) begin
         w_flags = 5'b00101;
         case (r_s1_mode)
            RM_RTZ:  w_res = {r_s1_sign, MAX_FINITE[30:0]};
            RM_RDN:  w_res = r_s1_sign ? {1'b1, INF_MAG} : {1'b0, MAX_FINITE[30:0]};
            RM_RUP:  w_res = r_s1_sign ? {1'b1, MAX_FINITE[30:0]} : {1'b0, INF_MAG};
            default: w_res = {r_s1_sign, INF_MAG};
         endcase
      end else begin
         w_res      = (r_s1_zero & ~r_s1_inx) ? {r_s1_sign, 31'd0} : {r_s1_sign, w_sum};
         w_flags[0] = r_s1_inx;
         w_flags[1] = (r_s1_uf_in | (r_s1_mag[30:23] == 8'd0)) & r_s1_inx;
      end
   end

   // ---------------- stage-2 registers (outputs)
   logic [31:0] r_result;
   logic [4:0]  r_fflags;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid  <= 1'b0;
         r_result <= 32'd0;
         r_fflags <= 5'd0;
      end else if (clk_en_i & w_s2_adv) begin
         r_valid <= r_s1_valid;
         // keep the last result on the bus when a bubble moves in
         if (r_s1_valid) begin
            r_result <= w_res;
            r_fflags <= w_flags;
         end
      end
   end

   assign valid_o  = r_valid;
   assign result_o = r_result;
   assign fflags_o = r_fflags;

endmodule

// File: tb/tb_fp_round_unit.sv
// Purpose : directed self-checking bench for fp_round_unit.
// Latency : checks 2-cycle accept-to-valid latency and in-order delivery.
// Backpressure: exercises ready_i stalls, clk_en_i freeze and mid-flight reset.
module tb_fp_round_unit;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        clk_en_i = 1'b1;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [31:0] to_round_i = 32'd0;
   logic [2:0]  round_bits_i = 3'd0;
   logic [2:0]  rounding_mode_i = 3'd0;
   logic        overflow_i = 1'b0;
   logic        underflow_i = 1'b0;
   logic        invalid_op_i = 1'b0;
   logic        zero_divide_i = 1'b0;
   logic        valid_o;
   logic        ready_i = 1'b1;
   logic [31:0] result_o;
   logic [4:0]  fflags_o;

   int tests = 0;
   int fails = 0;

   localparam logic [2:0] RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011, RMM = 3'b100;
   // exc field order: {overflow, underflow, invalid, zero_divide}
   typedef struct packed {
      logic [31:0] val;
      logic [2:0]  grs;
      logic [2:0]  rm;
      logic [3:0]  exc;
      logic [31:0] res;
      logic [4:0]  fl;
   } vec_t;

   fp_round_unit dut (
      .clk_i(clk_i), .rst_i(rst_i), .clk_en_i(clk_en_i),
      .valid_i(valid_i), .ready_o(ready_o),
      .to_round_i(to_round_i), .round_bits_i(round_bits_i), .rounding_mode_i(rounding_mode_i),
      .overflow_i(overflow_i), .underflow_i(underflow_i),
      .invalid_op_i(invalid_op_i), .zero_divide_i(zero_divide_i),
      .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .fflags_o(fflags_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
      $fatal(1);
   end

   // Drives one operand into an idle pipe and waits (bounded) for its result.
   // lat counts edges from the accepting edge to the one that raises valid_o.
   task automatic send_op(input logic [31:0] val, input logic [2:0] grs, input logic [2:0] rm,
                          input logic [3:0] exc, output logic [31:0] res, output logic [4:0] fl,
                          output int lat);
      to_round_i      = val;
      round_bits_i    = grs;
      rounding_mode_i = rm;
      {overflow_i, underflow_i, invalid_op_i, zero_divide_i} = exc;
      valid_i = 1'b1;
      ready_i = 1'b1;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      {overflow_i, underflow_i, invalid_op_i, zero_divide_i} = 4'b0000;
      lat = 1;
      while (!valid_o && lat < 20) begin
         @(posedge clk_i); #1;
         lat++;
      end
      res = result_o;
      fl  = fflags_o;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset valid_o: got %b expected 0", valid_o); end
      tests++; if (result_o !== 32'd0) begin fails++; $display("FAIL reset result_o: got %h expected 00000000", result_o); end
      tests++; if (fflags_o !== 5'd0) begin fails++; $display("FAIL reset fflags_o: got %b expected 00000", fflags_o); end
      tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL reset ready_o: got %b expected 1", ready_o); end
   endtask

   task automatic test_rne();
      vec_t v[5];
      logic [31:0] r; logic [4:0] f; int lat;
      v[0] = '{32'h3F800000, 3'b100, RNE, 4'b0000, 32'h3F800000, 5'b00001};
      v[1] = '{32'h3F800001, 3'b100, RNE, 4'b0000, 32'h3F800002, 5'b00001};
      v[2] = '{32'h3F800000, 3'b100, RMM, 4'b0000, 32'h3F800001, 5'b00001};
      v[3] = '{32'h00000001, 3'b100, RNE, 4'b0000, 32'h00000002, 5'b00011};
      v[4] = '{32'h3F800000, 3'b011, RNE, 4'b0000, 32'h3F800000, 5'b00001};
      for (int i = 0; i < 5; i++) begin
         send_op(v[i].val, v[i].grs, v[i].rm, v[i].exc, r, f, lat);
         tests++; if (r !== v[i].res) begin fails++; $display("FAIL rne[%0d] result: got %h expected %h", i, r, v[i].res); end
         tests++; if (f !== v[i].fl) begin fails++; $display("FAIL rne[%0d] fflags: got %b expected %b", i, f, v[i].fl); end
         tests++; if (lat != 2) begin fails++; $display("FAIL rne[%0d] latency: got %0d expected 2", i, lat); end
      end
   endtask

   task automatic test_carry_overflow();
      vec_t v[5];
      logic [31:0] r; logic [4:0] f; int lat;
      v[0] = '{32'h3FFFFFFF, 3'b110, RNE, 4'b0000, 32'h40000000, 5'b00001};
      v[1] = '{32'h7F7FFFFF, 3'b100, RNE, 4'b0000, 32'h7F800000, 5'b00101};
      v[2] = '{32'h7F7FFFFF, 3'b100, RTZ, 4'b0000, 32'h7F7FFFFF, 5'b00001};
      v[3] = '{32'hFF7FFFFF, 3'b100, RDN, 4'b0000, 32'hFF800000, 5'b00101};
      v[4] = '{32'h7F7FFFFF, 3'b100, RUP, 4'b0000, 32'h7F800000, 5'b00101};
      for (int i = 0; i < 5; i++) begin
         send_op(v[i].val, v[i].grs, v[i].rm, v[i].exc, r, f, lat);
         tests++; if (r !== v[i].res) begin fails++; $display("FAIL carry[%0d] result: got %h expected %h", i, r, v[i].res); end
         tests++; if (f !== v[i].fl) begin fails++; $display("FAIL carry[%0d] fflags: got %b expected %b", i, f, v[i].fl); end
      end
   endtask

   task automatic test_directed();
      vec_t v[6];
      logic [31:0] r; logic [4:0] f; int lat;
      v[0] = '{32'hBF800000, 3'b001, RDN, 4'b0000, 32'hBF800001, 5'b00001};
      v[1] = '{32'hBF800000, 3'b001, RUP, 4'b0000, 32'hBF800000, 5'b00001};
      v[2] = '{32'hBF800000, 3'b001, RTZ, 4'b0000, 32'hBF800000, 5'b00001};
      v[3] = '{32'h7F800000, 3'b000, RDN, 4'b1000, 32'h7F7FFFFF, 5'b00101};
      v[4] = '{32'hFF000000, 3'b000, RUP, 4'b1000, 32'hFF7FFFFF, 5'b00101};
      v[5] = '{32'h7F000000, 3'b000, RTZ, 4'b1000, 32'h7F7FFFFF, 5'b00101};
      for (int i = 0; i < 6; i++) begin
         send_op(v[i].val, v[i].grs, v[i].rm, v[i].exc, r, f, lat);
         tests++; if (r !== v[i].res) begin fails++; $display("FAIL directed[%0d] result: got %h expected %h", i, r, v[i].res); end
         tests++; if (f !== v[i].fl) begin fails++; $display("FAIL directed[%0d] fflags: got %b expected %b", i, f, v[i].fl); end
      end
   endtask

   task automatic test_specials();
      vec_t v[9];
      logic [31:0] r; logic [4:0] f; int lat;
      v[0] = '{32'h3F800000, 3'b000, RNE,    4'b0010, 32'h7FC00000, 5'b10000};
      v[1] = '{32'hBF800000, 3'b000, RNE,    4'b0001, 32'hFF800000, 5'b01000};
      v[2] = '{32'h7F800001, 3'b000, RNE,    4'b0000, 32'h7FC00000, 5'b10000};
      v[3] = '{32'h7FC00001, 3'b000, RNE,    4'b0000, 32'h7FC00000, 5'b00000};
      v[4] = '{32'hFF800000, 3'b101, RNE,    4'b0000, 32'hFF800000, 5'b00000};
      v[5] = '{32'h80000000, 3'b000, RNE,    4'b0000, 32'h80000000, 5'b00000};
      v[6] = '{32'h3F800000, 3'b100, 3'b101, 4'b0000, 32'h7FC00000, 5'b10000};
      v[7] = '{32'h3F800000, 3'b000, RNE,    4'b0011, 32'h7FC00000, 5'b10000};
      v[8] = '{32'h00000000, 3'b000, RNE,    4'b0100, 32'h00000000, 5'b00000};
      for (int i = 0; i < 9; i++) begin
         send_op(v[i].val, v[i].grs, v[i].rm, v[i].exc, r, f, lat);
         tests++; if (r !== v[i].res) begin fails++; $display("FAIL special[%0d] result: got %h expected %h", i, r, v[i].res); end
         tests++; if (f !== v[i].fl) begin fails++; $display("FAIL special[%0d] fflags: got %b expected %b", i, f, v[i].fl); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ops[4], exp_r[4], got_r[8];
      logic [2:0]  grs[4], rms[4];
      logic [4:0]  exp_f[4], got_f[8];
      int n_in, n_out;
      ops[0] = 32'h3F800000; grs[0] = 3'b000; rms[0] = RNE; exp_r[0] = 32'h3F800000; exp_f[0] = 5'b00000;
      ops[1] = 32'h3F800001; grs[1] = 3'b100; rms[1] = RNE; exp_r[1] = 32'h3F800002; exp_f[1] = 5'b00001;
      ops[2] = 32'h40000000; grs[2] = 3'b010; rms[2] = RUP; exp_r[2] = 32'h40000001; exp_f[2] = 5'b00001;
      ops[3] = 32'hC0000000; grs[3] = 3'b001; rms[3] = RDN; exp_r[3] = 32'hC0000001; exp_f[3] = 5'b00001;
      for (int i = 0; i < 8; i++) begin got_r[i] = 32'd0; got_f[i] = 5'd0; end
      // drain any result left from earlier tests
      valid_i = 1'b0; ready_i = 1'b1;
      @(posedge clk_i); #1;
      n_in = 0; n_out = 0;
      for (int c = 0; c < 16; c++) begin
         ready_i = !(c >= 2 && c <= 5);
         if (n_in < 4) begin
            valid_i = 1'b1; to_round_i = ops[n_in]; round_bits_i = grs[n_in]; rounding_mode_i = rms[n_in];
         end else begin
            valid_i = 1'b0;
         end
         #1;
         if (c >= 2 && c <= 5) begin
            tests++; if (ready_o !== 1'b0) begin fails++; $display("FAIL b2b ready_o cycle %0d: got %b expected 0", c, ready_o); end
            tests++; if (valid_o !== 1'b1 || result_o !== exp_r[0]) begin
               fails++; $display("FAIL b2b stall hold cycle %0d: got valid=%b result=%h expected valid=1 result=%h", c, valid_o, result_o, exp_r[0]);
            end
         end
         if (valid_o && ready_i) begin
            if (n_out < 8) begin got_r[n_out] = result_o; got_f[n_out] = fflags_o; end
            n_out++;
         end
         if (valid_i && ready_o) n_in++;
         @(posedge clk_i); #1;
      end
      valid_i = 1'b0; ready_i = 1'b1;
      tests++; if (n_out != 4) begin fails++; $display("FAIL b2b count: got %0d results expected 4", n_out); end
      for (int i = 0; i < 4; i++) begin
         tests++; if (got_r[i] !== exp_r[i]) begin fails++; $display("FAIL b2b order[%0d] result: got %h expected %h", i, got_r[i], exp_r[i]); end
         tests++; if (got_f[i] !== exp_f[i]) begin fails++; $display("FAIL b2b order[%0d] fflags: got %b expected %b", i, got_f[i], exp_f[i]); end
      end
   endtask

   task automatic test_clk_en();
      // park one result at the output, held by ready_i=0
      to_round_i = 32'h3F800000; round_bits_i = 3'b100; rounding_mode_i = RMM;
      valid_i = 1'b1; ready_i = 1'b0;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      @(posedge clk_i); #1;
      // freeze with a consumer ready and a new operand offered
      clk_en_i = 1'b0; ready_i = 1'b1; valid_i = 1'b1; to_round_i = 32'h40400000; round_bits_i = 3'b000;
      for (int c = 0; c < 3; c++) begin
         #1;
         tests++; if (ready_o !== 1'b0) begin fails++; $display("FAIL clk_en ready_o cycle %0d: got %b expected 0", c, ready_o); end
         tests++; if (valid_o !== 1'b1 || result_o !== 32'h3F800001 || fflags_o !== 5'b00001) begin
            fails++; $display("FAIL clk_en hold cycle %0d: got valid=%b result=%h fflags=%b expected 1 3f800001 00001", c, valid_o, result_o, fflags_o);
         end
         @(posedge clk_i); #1;
      end
      valid_i = 1'b0; clk_en_i = 1'b1;
      @(posedge clk_i); #1;
      tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL clk_en release: got valid_o=%b expected 0", valid_o); end
   endtask

   task automatic test_reset_midflight();
      logic [31:0] r; logic [4:0] f; int lat;
      ready_i = 1'b1; rounding_mode_i = RNE;
      valid_i = 1'b1; to_round_i = 32'h3F800000; round_bits_i = 3'b100;
      @(posedge clk_i); #1;
      to_round_i = 32'h40000000; round_bits_i = 3'b000;
      @(posedge clk_i); #1;
      valid_i = 1'b0; rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      tests++; if (valid_o !== 1'b0 || result_o !== 32'd0 || fflags_o !== 5'd0) begin
         fails++; $display("FAIL midreset outputs: got valid=%b result=%h fflags=%b expected 0 00000000 00000", valid_o, result_o, fflags_o);
      end
      @(posedge clk_i); #1;
      tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL midreset replay: got valid_o=%b expected 0", valid_o); end
      send_op(32'h3F800001, 3'b110, RNE, 4'b0000, r, f, lat);
      tests++; if (lat != 2) begin fails++; $display("FAIL midreset latency: got %0d expected 2", lat); end
      tests++; if (r !== 32'h3F800002) begin fails++; $display("FAIL midreset result: got %h expected 3f800002", r); end
      tests++; if (f !== 5'b00001) begin fails++; $display("FAIL midreset fflags: got %b expected 00001", f); end
   endtask

   initial begin
      test_reset();
      test_rne();
      test_carry_overflow();
      test_directed();
      test_specials();
      test_back_to_back();
      test_clk_en();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
